// File: rtl/periph_bridge_pkg.sv
// Shared types for the OBI -> XBAR_PERIPH_BUS initiator bridge.
// Optional response timeout is enabled with `define PERIPH_BRIDGE_TIMEOUT_EN.
package periph_bridge_pkg;

  localparam int MAX_AID_WIDTH = 16;
  localparam int TIMER_WIDTH   = 16;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef logic [3:0] slot_idx_t;

  typedef struct packed {
    logic                     valid;
    logic                     zombie;
    logic [MAX_AID_WIDTH-1:0] aid;
    logic [TIMER_WIDTH-1:0]   timer;
  } slot_entry_t;

endpackage

// File: rtl/xbar_periph_bus.sv
// Peripheral interconnect bus: request channel plus out-of-order, id-tagged response channel.
interface XBAR_PERIPH_BUS #(
  parameter int ID_WIDTH = 6
);
  logic                req;
  logic [31:0]         add;
  logic                wen;
  logic [31:0]         wdata;
  logic [3:0]          be;
  logic                gnt;
  logic [ID_WIDTH-1:0] id;
  logic                r_valid;
  logic                r_opc;
  logic [ID_WIDTH-1:0] r_id;
  logic [31:0]         r_rdata;

  modport Master (
    output req, add, wen, wdata, be, id,
    input  gnt, r_valid, r_opc, r_id, r_rdata
  );

  modport Slave (
    input  req, add, wen, wdata, be, id,
    output gnt, r_valid, r_opc, r_id, r_rdata
  );
endinterface

// File: rtl/periph_slot_table.sv
// Outstanding-transaction table: valid mask, lowest-free encoder, aid store and optional timers.
// Timers and zombie slots exist only with `define PERIPH_BRIDGE_TIMEOUT_EN.
module periph_slot_table
  import periph_bridge_pkg::*;
#(
  parameter int AID_WIDTH      = 4,
  parameter int NUM_SLOTS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_i,
  input  logic [AID_WIDTH-1:0] alloc_aid_i,
  input  logic                 free_i,
  input  slot_idx_t            lookup_idx_i,
  output logic                 lookup_valid_o,
  output logic                 lookup_zombie_o,
  output logic [AID_WIDTH-1:0] lookup_aid_o,
  output slot_idx_t            free_idx_o,
  output logic                 full_o,
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
  input  logic                 timeout_ack_i,
  output logic                 timeout_req_o,
  output logic [AID_WIDTH-1:0] timeout_aid_o,
`endif
  output logic                 busy_o
);

  slot_entry_t slots_q [NUM_SLOTS];
  slot_entry_t slots_d [NUM_SLOTS];

  // Descending scan so the last write wins with the lowest free index.
  always_comb begin
    full_o     = 1'b1;
    busy_o     = 1'b0;
    free_idx_o = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slots_q[i].valid) begin
        busy_o = 1'b1;
      end else begin
        full_o     = 1'b0;
        free_idx_o = slot_idx_t'(i);
      end
    end
  end

  always_comb begin
    lookup_valid_o  = 1'b0;
    lookup_zombie_o = 1'b0;
    lookup_aid_o    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_idx_t'(i) == lookup_idx_i) begin
        lookup_valid_o  = slots_q[i].valid;
        lookup_zombie_o = slots_q[i].zombie;
        lookup_aid_o    = slots_q[i].aid[AID_WIDTH-1:0];
      end
    end
  end

`ifdef PERIPH_BRIDGE_TIMEOUT_EN
  slot_idx_t timeout_idx;

  // A slot expires on its last counted cycle and stays pending at 0 until the response slot is free.
  always_comb begin
    timeout_req_o = 1'b0;
    timeout_idx   = '0;
    timeout_aid_o = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slots_q[i].valid && !slots_q[i].zombie && slots_q[i].timer <= TIMER_WIDTH'(1)) begin
        timeout_req_o = 1'b1;
        timeout_idx   = slot_idx_t'(i);
        timeout_aid_o = slots_q[i].aid[AID_WIDTH-1:0];
      end
    end
  end
`endif

  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
      if (slots_q[i].valid && !slots_q[i].zombie && slots_q[i].timer != '0) begin
        slots_d[i].timer = slots_q[i].timer - TIMER_WIDTH'(1);
      end
      if (timeout_ack_i && timeout_idx == slot_idx_t'(i)) begin
        slots_d[i].zombie = 1'b1;
      end
`endif
      if (free_i && lookup_idx_i == slot_idx_t'(i)) begin
        slots_d[i] = '0;
      end
      if (alloc_i && !full_o && free_idx_o == slot_idx_t'(i)) begin
        slots_d[i].valid  = 1'b1;
        slots_d[i].zombie = 1'b0;
        slots_d[i].aid    = MAX_AID_WIDTH'(alloc_aid_i);
        slots_d[i].timer  = TIMER_WIDTH'(TIMEOUT_CYCLES);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      slots_q <= slots_d;
    end
  end

endmodule

// File: rtl/obi_xbar_periph_bridge.sv
// OBI initiator to XBAR_PERIPH_BUS master bridge with slot-indexed ids and aid restore on response.
// `define PERIPH_BRIDGE_TIMEOUT_EN adds per-slot response timeouts with error responses.
module obi_xbar_periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter int ID_WIDTH       = 6,
  parameter int AID_WIDTH      = 4,
  parameter int NUM_SLOTS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 obi_req_i,
  output logic                 obi_gnt_o,
  input  logic [31:0]          obi_addr_i,
  input  logic                 obi_we_i,
  input  logic [3:0]           obi_be_i,
  input  logic [31:0]          obi_wdata_i,
  input  logic [AID_WIDTH-1:0] obi_aid_i,
  output logic                 obi_rvalid_o,
  output logic [31:0]          obi_rdata_o,
  output logic                 obi_err_o,
  output logic [AID_WIDTH-1:0] obi_rid_o,
  XBAR_PERIPH_BUS.Master       periph,
  output logic                 busy_o,
  output logic                 spurious_o
);

  logic                 full;
  slot_idx_t            free_idx;
  slot_idx_t            lookup_idx;
  logic                 lookup_valid;
  logic                 lookup_zombie;
  logic [AID_WIDTH-1:0] lookup_aid;
  logic                 fire;
  logic                 in_range;
  logic                 hit;
  logic                 live_hit;

  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [AID_WIDTH-1:0] rid_q, rid_d;
  logic                 spurious_q, spurious_d;

`ifdef PERIPH_BRIDGE_TIMEOUT_EN
  logic                 timeout_req;
  logic                 timeout_ack;
  logic [AID_WIDTH-1:0] timeout_aid;
`endif

  assign periph.req   = obi_req_i & ~full;
  assign periph.add   = obi_addr_i;
  assign periph.wdata = obi_wdata_i;
  assign periph.be    = obi_be_i;
  assign periph.wen   = ~obi_we_i;
  assign periph.id    = ID_WIDTH'(free_idx);
  assign obi_gnt_o    = periph.gnt & ~full;

  assign fire       = periph.req & periph.gnt;
  assign in_range   = int'(periph.r_id) < NUM_SLOTS;
  assign lookup_idx = slot_idx_t'(periph.r_id);
  assign hit        = periph.r_valid & in_range & lookup_valid;
  assign live_hit   = hit & ~lookup_zombie;

  periph_slot_table #(
    .AID_WIDTH      (AID_WIDTH),
    .NUM_SLOTS      (NUM_SLOTS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_slot_table (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .alloc_i         (fire),
    .alloc_aid_i     (obi_aid_i),
    .free_i          (hit),
    .lookup_idx_i    (lookup_idx),
    .lookup_valid_o  (lookup_valid),
    .lookup_zombie_o (lookup_zombie),
    .lookup_aid_o    (lookup_aid),
    .free_idx_o      (free_idx),
    .full_o          (full),
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    .timeout_ack_i   (timeout_ack),
    .timeout_req_o   (timeout_req),
    .timeout_aid_o   (timeout_aid),
`endif
    .busy_o          (busy_o)
  );

  // A genuine periph response always wins the single OBI response slot over a timeout.
  always_comb begin
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    rid_d      = rid_q;
    spurious_d = spurious_q | (periph.r_valid & ~hit);
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    timeout_ack = 1'b0;
`endif
    if (live_hit) begin
      rvalid_d = 1'b1;
      rdata_d  = periph.r_rdata;
      err_d    = periph.r_opc;
      rid_d    = lookup_aid;
    end
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    else if (timeout_req) begin
      rvalid_d    = 1'b1;
      rdata_d     = TIMEOUT_RDATA;
      err_d       = 1'b1;
      rid_d       = timeout_aid;
      timeout_ack = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rid_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      rid_q      <= rid_d;
      spurious_q <= spurious_d;
    end
  end

  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;
  assign obi_rid_o    = rid_q;
  assign spurious_o   = spurious_q;

endmodule

// File: tb/tb_obi_xbar_periph_bridge.sv
// Directed bench for obi_xbar_periph_bridge: transaction-level model compared every cycle plus literal checks.
// Follows `define PERIPH_BRIDGE_TIMEOUT_EN to select the timeout or no-timeout scenario.
module tb_obi_xbar_periph_bridge;

  localparam int ID_W   = 6;
  localparam int AID_W  = 4;
  localparam int NSLOTS = 4;
  localparam int TMO    = 8;

  logic             clock = 1'b0;
  logic             rstN  = 1'b0;
  logic             obiReq = 1'b0;
  logic             obiGnt;
  logic [31:0]      obiAddr = '0;
  logic             obiWe = 1'b0;
  logic [3:0]       obiBe = '0;
  logic [31:0]      obiWdata = '0;
  logic [AID_W-1:0] obiAid = '0;
  logic             obiRvalid;
  logic [31:0]      obiRdata;
  logic             obiErr;
  logic [AID_W-1:0] obiRid;
  logic             busy;
  logic             spurious;

  XBAR_PERIPH_BUS #(.ID_WIDTH(ID_W)) periphBus ();

  obi_xbar_periph_bridge #(
    .ID_WIDTH       (ID_W),
    .AID_WIDTH      (AID_W),
    .NUM_SLOTS      (NSLOTS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i        (clock),
    .rst_ni       (rstN),
    .obi_req_i    (obiReq),
    .obi_gnt_o    (obiGnt),
    .obi_addr_i   (obiAddr),
    .obi_we_i     (obiWe),
    .obi_be_i     (obiBe),
    .obi_wdata_i  (obiWdata),
    .obi_aid_i    (obiAid),
    .obi_rvalid_o (obiRvalid),
    .obi_rdata_o  (obiRdata),
    .obi_err_o    (obiErr),
    .obi_rid_o    (obiRid),
    .periph       (periphBus),
    .busy_o       (busy),
    .spurious_o   (spurious)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: which slots hold which aid, and what the OBI response must be next cycle.
  logic             mBusy   [NSLOTS];
  logic             mZombie [NSLOTS];
  logic [AID_W-1:0] mAid    [NSLOTS];
  int               mAge    [NSLOTS];
  logic             mSpurious;
  logic             mRvalid;
  logic             mErr;
  logic [31:0]      mRdata;
  logic [AID_W-1:0] mRid;

  function automatic int modelFreeSlot();
    for (int k = 0; k < NSLOTS; k++) begin
      if (!mBusy[k]) return k;
    end
    return -1;
  endfunction

  task automatic modelClear();
    for (int k = 0; k < NSLOTS; k++) begin
      mBusy[k] = 1'b0; mZombie[k] = 1'b0; mAid[k] = '0; mAge[k] = 0;
    end
    mSpurious = 1'b0; mRvalid = 1'b0; mErr = 1'b0; mRdata = '0; mRid = '0;
  endtask

  task automatic modelStep();
    int freeSlot;
    int rid;
    logic fire;
    freeSlot = modelFreeSlot();
    fire     = obiReq && periphBus.gnt && (freeSlot >= 0);
    mRvalid  = 1'b0;
    if (periphBus.r_valid) begin
      rid = int'(periphBus.r_id);
      if (rid < NSLOTS && mBusy[rid]) begin
        if (!mZombie[rid]) begin
          mRvalid = 1'b1; mRdata = periphBus.r_rdata; mErr = periphBus.r_opc; mRid = mAid[rid];
        end
        mBusy[rid] = 1'b0; mZombie[rid] = 1'b0;
      end else begin
        mSpurious = 1'b1;
      end
    end
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    if (!mRvalid) begin
      for (int k = 0; k < NSLOTS; k++) begin
        if (!mRvalid && mBusy[k] && !mZombie[k] && mAge[k] >= TMO - 1) begin
          mRvalid = 1'b1; mRdata = 32'hDEAD_BEEF; mErr = 1'b1; mRid = mAid[k]; mZombie[k] = 1'b1;
        end
      end
    end
    for (int k = 0; k < NSLOTS; k++) begin
      if (mBusy[k] && !mZombie[k]) mAge[k]++;
    end
`endif
    if (fire) begin
      mBusy[freeSlot] = 1'b1; mZombie[freeSlot] = 1'b0; mAid[freeSlot] = obiAid; mAge[freeSlot] = 0;
    end
  endtask

  initial begin
    modelClear();
    forever begin
      @(posedge clock or negedge rstN);
      if (!rstN) modelClear();
      else modelStep();
    end
  end

  // Every mid-cycle out of reset, all outputs are held against the model.
  initial begin
    int  freeSlot;
    logic anyBusy;
    forever begin
      @(negedge clock);
      if (rstN) begin
        freeSlot = modelFreeSlot();
        anyBusy  = 1'b0;
        for (int k = 0; k < NSLOTS; k++) anyBusy |= mBusy[k];
        checkOutput("mdlPeriphReq", 32'(periphBus.req), 32'(obiReq && freeSlot >= 0));
        checkOutput("mdlObiGnt", 32'(obiGnt), 32'(periphBus.gnt && freeSlot >= 0));
        if (freeSlot >= 0) checkOutput("mdlPeriphId", 32'(periphBus.id), freeSlot);
        if (obiReq) begin
          checkOutput("mdlAdd", periphBus.add, obiAddr);
          checkOutput("mdlWdata", periphBus.wdata, obiWdata);
          checkOutput("mdlBe", 32'(periphBus.be), 32'(obiBe));
          checkOutput("mdlWen", 32'(periphBus.wen), 32'(!obiWe));
        end
        checkOutput("mdlBusy", 32'(busy), 32'(anyBusy));
        checkOutput("mdlSpurious", 32'(spurious), 32'(mSpurious));
        checkOutput("mdlRvalid", 32'(obiRvalid), 32'(mRvalid));
        if (mRvalid) begin
          checkOutput("mdlRdata", obiRdata, mRdata);
          checkOutput("mdlErr", 32'(obiErr), 32'(mErr));
          checkOutput("mdlRid", 32'(obiRid), 32'(mRid));
        end
      end
    end
  end

  // Drive one cycle's inputs just after the clock edge, then wait to mid-cycle for checks.
  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input logic [AID_W-1:0] aid, input logic gnt,
                               input logic rv, input logic [ID_W-1:0] rid, input logic [31:0] rdata,
                               input logic opc);
    @(posedge clock);
    #1;
    obiReq = req; obiWe = we; obiAddr = addr; obiBe = be; obiWdata = wdata; obiAid = aid;
    periphBus.gnt = gnt; periphBus.r_valid = rv; periphBus.r_id = rid;
    periphBus.r_rdata = rdata; periphBus.r_opc = opc;
    @(negedge clock);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic respond(input logic [ID_W-1:0] rid, input logic [31:0] rdata, input logic opc);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, rid, rdata, opc);
  endtask

  initial begin
    periphBus.gnt = 1'b0; periphBus.r_valid = 1'b0; periphBus.r_id = '0;
    periphBus.r_rdata = '0; periphBus.r_opc = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rstRvalid", 32'(obiRvalid), 0);
    checkOutput("rstRdata", obiRdata, 0);
    checkOutput("rstRid", 32'(obiRid), 0);
    checkOutput("rstErr", 32'(obiErr), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstSpurious", 32'(spurious), 0);
    @(posedge clock);
    #1 rstN = 1'b1;

    // Single read, granted immediately, answered two cycles later
    applyStimulus(1'b1, 1'b0, 32'h1000_0040, 4'hF, '0, 4'd3, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("rdWen", 32'(periphBus.wen), 1);
    checkOutput("rdId", 32'(periphBus.id), 0);
    checkOutput("rdGnt", 32'(obiGnt), 1);
    checkOutput("rdAdd", periphBus.add, 32'h1000_0040);
    idleCycle();
    checkOutput("rdBusy", 32'(busy), 1);
    respond(6'd0, 32'hCAFE_0001, 1'b0);
    checkOutput("rdRvalidEarly", 32'(obiRvalid), 0);
    idleCycle();
    checkOutput("rdRvalid", 32'(obiRvalid), 1);
    checkOutput("rdRdata", obiRdata, 32'hCAFE_0001);
    checkOutput("rdRid", 32'(obiRid), 3);
    checkOutput("rdErr", 32'(obiErr), 0);
    checkOutput("rdBusyAfter", 32'(busy), 0);

    // Write with partial byte enables, answered with an error opcode
    applyStimulus(1'b1, 1'b1, 32'h1000_0080, 4'b0011, 32'h1234_5678, 4'd5, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("wrWen", 32'(periphBus.wen), 0);
    checkOutput("wrBe", 32'(periphBus.be), 32'h3);
    checkOutput("wrWdata", periphBus.wdata, 32'h1234_5678);
    checkOutput("wrId", 32'(periphBus.id), 0);
    respond(6'd0, 32'h0, 1'b1);
    idleCycle();
    checkOutput("wrRvalid", 32'(obiRvalid), 1);
    checkOutput("wrErr", 32'(obiErr), 1);
    checkOutput("wrRid", 32'(obiRid), 5);

    // Fill all four slots, then a fifth request stalls until a slot frees
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h1000_0100 + 32'(k * 4), 4'hF, '0, AID_W'(k), 1'b1, 1'b0, '0, '0, 1'b0);
      checkOutput("fillId", 32'(periphBus.id), k - 1);
      checkOutput("fillGnt", 32'(obiGnt), 1);
    end
    applyStimulus(1'b1, 1'b0, 32'h1000_0200, 4'hF, '0, 4'd5, 1'b1, 1'b1, 6'd2, 32'hA5A5_0002, 1'b0);
    checkOutput("fullGnt", 32'(obiGnt), 0);
    checkOutput("fullReq", 32'(periphBus.req), 0);
    checkOutput("fullBusy", 32'(busy), 1);
    applyStimulus(1'b1, 1'b0, 32'h1000_0200, 4'hF, '0, 4'd5, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("reuseGnt", 32'(obiGnt), 1);
    checkOutput("reuseId", 32'(periphBus.id), 2);
    checkOutput("reuseRvalid", 32'(obiRvalid), 1);
    checkOutput("reuseRid", 32'(obiRid), 3);
    checkOutput("reuseRdata", obiRdata, 32'hA5A5_0002);

    // Out-of-order drain: slot ids 3,0,1,2 carry aids 4,1,2,5
    respond(6'd3, 32'hB0B0_0003, 1'b0);
    respond(6'd0, 32'hB0B0_0000, 1'b0);
    checkOutput("oooRid0", 32'(obiRid), 4);
    checkOutput("oooRdata0", obiRdata, 32'hB0B0_0003);
    respond(6'd1, 32'hB0B0_0001, 1'b0);
    checkOutput("oooRid1", 32'(obiRid), 1);
    respond(6'd2, 32'hB0B0_0002, 1'b0);
    checkOutput("oooRid2", 32'(obiRid), 2);
    idleCycle();
    checkOutput("oooRid3", 32'(obiRid), 5);
    idleCycle();
    checkOutput("oooBusy", 32'(busy), 0);
    checkOutput("oooRvalidIdle", 32'(obiRvalid), 0);

    // Unanswered request: times out only when the timeout feature is built in
    applyStimulus(1'b1, 1'b0, 32'h1000_0300, 4'hF, '0, 4'd7, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("tmoId", 32'(periphBus.id), 0);
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    for (int c = 1; c <= TMO; c++) begin
      idleCycle();
      checkOutput("tmoEarly", 32'(obiRvalid), 0);
    end
    idleCycle();
    checkOutput("tmoRvalid", 32'(obiRvalid), 1);
    checkOutput("tmoErr", 32'(obiErr), 1);
    checkOutput("tmoRdata", obiRdata, 32'hDEAD_BEEF);
    checkOutput("tmoRid", 32'(obiRid), 7);
    checkOutput("tmoZombieBusy", 32'(busy), 1);
    idleCycle();
    checkOutput("tmoOnce", 32'(obiRvalid), 0);
    respond(6'd0, 32'h1111_1111, 1'b0);
    idleCycle();
    checkOutput("tmoLateDrop", 32'(obiRvalid), 0);
    checkOutput("tmoLateFree", 32'(busy), 0);
    checkOutput("tmoLateQuiet", 32'(spurious), 0);
`else
    for (int c = 1; c <= 20; c++) begin
      idleCycle();
      checkOutput("noTmoWait", 32'(obiRvalid), 0);
    end
    checkOutput("noTmoBusy", 32'(busy), 1);
    respond(6'd0, 32'h1111_1111, 1'b0);
    idleCycle();
    checkOutput("noTmoRvalid", 32'(obiRvalid), 1);
    checkOutput("noTmoRid", 32'(obiRid), 7);
    checkOutput("noTmoRdata", obiRdata, 32'h1111_1111);
    checkOutput("noTmoFree", 32'(busy), 0);
`endif

    // Response for an id that was never issued
    respond(6'd5, 32'h5555_5555, 1'b0);
    idleCycle();
    checkOutput("spurRvalid", 32'(obiRvalid), 0);
    checkOutput("spurFlag", 32'(spurious), 1);
    repeat (3) idleCycle();
    checkOutput("spurSticky", 32'(spurious), 1);

    // Reset with a transaction in flight; its late response becomes spurious
    applyStimulus(1'b1, 1'b0, 32'h1000_0400, 4'hF, '0, 4'd9, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("rstMidGnt", 32'(obiGnt), 1);
    @(posedge clock);
    #1 rstN = 1'b0;
    obiReq = 1'b0; periphBus.gnt = 1'b0;
    @(negedge clock);
    checkOutput("rstMidBusy", 32'(busy), 0);
    checkOutput("rstMidSpur", 32'(spurious), 0);
    @(posedge clock);
    #1 rstN = 1'b1;
    respond(6'd0, 32'h9999_9999, 1'b0);
    idleCycle();
    checkOutput("lateRvalid", 32'(obiRvalid), 0);
    checkOutput("lateSpur", 32'(spurious), 1);
    repeat (2) idleCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
